// File: rtl/sync_fifo_flagged.sv
// sync_fifo_flagged: single-clock FIFO with occupancy count, almost/error flags
// and selectable registered or first-word-fall-through read.
module sync_fifo_flagged #(
   parameter int WIDTH         = 18,
   parameter int DEPTH         = 32,
   parameter bit FWFT          = 1'b0,
   parameter int AFULL_THRESH  = DEPTH - 4,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       d_in,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       d_out,
   output logic                   d_valid,
   output logic                   empty,
   output logic                   full,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow,
   input  logic                   clr_err
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] AF = AFULL_THRESH[AW:0];
   localparam logic [AW:0] AE = AEMPTY_THRESH[AW:0];
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic wr_acc, rd_acc;
   // MSB of each pointer is the wrap bit; equal addresses with differing wrap bits means full
   assign empty        = wr_ptr == rd_ptr;
   assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign almost_full  = count >= AF;
   assign almost_empty = count <= AE;
   assign wr_acc       = wr_en & ~full;
   assign rd_acc       = rd_en & ~empty;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         count     <= count + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
         overflow  <= (overflow & ~clr_err) | (wr_en & full);
         underflow <= (underflow & ~clr_err) | (rd_en & empty);
      end
   end
   always_ff @(posedge clk)
      if (wr_acc) mem[wr_ptr[AW-1:0]] <= d_in;
   generate
      if (FWFT) begin : g_fwft
         assign d_out   = mem[rd_ptr[AW-1:0]];
         assign d_valid = ~empty;
      end else begin : g_std
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               d_out   <= '0;
               d_valid <= 1'b0;
            end else begin
               d_valid <= rd_acc;
               if (rd_acc) d_out <= mem[rd_ptr[AW-1:0]];
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_sync_fifo_flagged.sv
// tb_sync_fifo_flagged: directed scoreboard bench driving a standard and an FWFT
// instance with the same stimulus and checking both against a queue model.
module tb_sync_fifo_flagged;
   logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
   logic [17:0] d_in = '0;
   logic [17:0] s_d_out, f_d_out;
   logic [5:0] s_count, f_count;
   logic s_d_valid, s_empty, s_full, s_af, s_ae, s_ovf, s_unf;
   logic f_d_valid, f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
   int vectors = 0, errs = 0;
   logic [17:0] q[$];
   logic [17:0] last = '0;
   logic ovf = 1'b0, unf = 1'b0;

   always #5 clk = ~clk;

   sync_fifo_flagged #(.WIDTH(18), .DEPTH(32), .FWFT(1'b0)) u_std (
      .clk(clk), .rst(rst), .wr_en(wr_en), .d_in(d_in), .rd_en(rd_en),
      .d_out(s_d_out), .d_valid(s_d_valid), .empty(s_empty), .full(s_full),
      .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
      .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err));

   sync_fifo_flagged #(.WIDTH(18), .DEPTH(32), .FWFT(1'b1)) u_fwft (
      .clk(clk), .rst(rst), .wr_en(wr_en), .d_in(d_in), .rd_en(rd_en),
      .d_out(f_d_out), .d_valid(f_d_valid), .empty(f_empty), .full(f_full),
      .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
      .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state();
      int n = q.size();
      chk("count", 32'(s_count), n);
      chk("empty", 32'(s_empty), 32'(n == 0));
      chk("full", 32'(s_full), 32'(n == 32));
      chk("almost_full", 32'(s_af), 32'(n >= 28));
      chk("almost_empty", 32'(s_ae), 32'(n <= 4));
      chk("overflow", 32'(s_ovf), 32'(ovf));
      chk("underflow", 32'(s_unf), 32'(unf));
      chk("d_out_hold", 32'(s_d_out), 32'(last));
      chk("f_count", 32'(f_count), n);
      chk("f_flags", {26'd0, f_empty, f_full, f_af, f_ae, f_ovf, f_unf},
          {26'd0, n == 0, n == 32, n >= 28, n <= 4, ovf, unf});
      chk("f_d_valid", 32'(f_d_valid), 32'(n != 0));
      if (n != 0) chk("f_d_out", 32'(f_d_out), 32'(q[0]));
   endtask

   task automatic step(input logic w, input logic r, input logic [17:0] d, input logic c);
      logic wa, ra;
      logic [17:0] exp;
      wr_en = w; rd_en = r; d_in = d; clr_err = c;
      wa = w && q.size() < 32;
      ra = r && q.size() > 0;
      ovf = (ovf && !c) || (w && q.size() == 32);
      unf = (unf && !c) || (r && q.size() == 0);
      @(posedge clk); #1;
      if (ra) begin
         exp = q.pop_front();
         last = exp;
      end
      if (wa) q.push_back(d);
      chk("d_valid", 32'(s_d_valid), 32'(ra));
      chk_state();
      wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
   endtask

   initial begin
      #2;
      chk_state();
      chk("rst_d_valid", 32'(s_d_valid), 32'd0);
      #10 rst = 1'b0;
      step(0, 0, 0, 0);
      for (int i = 0; i < 32; i++) step(1, 0, 18'(i), 0);
      step(1, 0, 18'h99, 0);
      step(0, 0, 0, 1);
      for (int i = 0; i < 32; i++) step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      step(1, 1, 18'h77, 0);
      step(0, 1, 0, 1);
      for (int i = 0; i < 20; i++) step(1, 0, 18'(200 + i), 0);
      for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
      for (int i = 0; i < 20; i++) step(1, 0, 18'(100 + i), 0);
      for (int i = 0; i < 10; i++) step(1, 1, 18'(300 + i), 0);
      for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
      step(1, 0, 18'h2ABC, 0);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      for (int i = 0; i < 12; i++) step(1, 0, 18'(400 + i), 0);
      #2 rst = 1'b1;
      q.delete();
      last = '0; ovf = 1'b0; unf = 1'b0;
      #1;
      chk_state();
      chk("async_d_valid", 32'(s_d_valid), 32'd0);
      #2 rst = 1'b0;
      step(1, 0, 18'h155, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
